// File: rtl/pea_result_drain.sv
// Drains the paired PEA result/status FIFOs and re-emits each record as four
// 16-bit words (status hi, status lo, result hi, result lo) on a valid/ready stream.
module pea_result_drain #(
  parameter int POP_W = 5,
  parameter int DW    = 32,
  parameter int OW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             drain_en,
  input  logic [POP_W-1:0] result_pop,
  input  logic [POP_W-1:0] status_pop,
  input  logic [DW-1:0]    result_data,
  input  logic [DW-1:0]    status_data,
  output logic             rd_en_result,
  output logic             rd_en_status,
  output logic [OW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] rec_count,
  output logic             sync_err,
  output logic [2:0]       dbg_state
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] POP  = 3'd1;
  localparam logic [2:0] CAP  = 3'd2;
  localparam logic [2:0] S0   = 3'd3;
  localparam logic [2:0] S1   = 3'd4;
  localparam logic [2:0] S2   = 3'd5;
  localparam logic [2:0] S3   = 3'd6;

  logic [2:0]    state;
  logic [DW-1:0] st_q;
  logic [DW-1:0] rs_q;
  logic          res_nz;
  logic          sts_nz;

  // Stream handshake: a word transfers on a rising edge where out_valid && out_ready;
  // out_data is held unchanged while out_valid && !out_ready.
  assign res_nz       = (result_pop != '0);
  assign sts_nz       = (status_pop != '0);
  assign rd_en_result = (state == POP);
  assign rd_en_status = (state == POP);
  assign out_valid    = (state == S0) || (state == S1) || (state == S2) || (state == S3);
  assign busy         = (state != IDLE);
  assign dbg_state    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      st_q      <= '0;
      rs_q      <= '0;
      out_data  <= '0;
      rec_count <= '0;
      sync_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (res_nz != sts_nz) sync_err <= 1'b1;
          if (drain_en && res_nz && sts_nz) state <= POP;
        end
        POP: state <= CAP;
        CAP: begin
          // FIFO heads become valid one cycle after the pop strobe.
          st_q     <= status_data;
          rs_q     <= result_data;
          out_data <= status_data[DW-1:OW];
          state    <= S0;
        end
        S0: if (out_ready) begin
          out_data <= st_q[OW-1:0];
          state    <= S1;
        end
        S1: if (out_ready) begin
          out_data <= rs_q[DW-1:OW];
          state    <= S2;
        end
        S2: if (out_ready) begin
          out_data <= rs_q[OW-1:0];
          state    <= S3;
        end
        S3: if (out_ready) begin
          rec_count <= rec_count + CNT_W'(1);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pea_result_drain.sv
// Bench for pea_result_drain: FIFO pair model with one-cycle read latency,
// word-order scoreboard, table-driven records, directed corners and random traffic.
module tb_pea_result_drain;

  localparam int POP_W = 5;
  localparam int DW    = 32;
  localparam int OW    = 16;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [31:0] st;
    logic [31:0] rs;
    logic [63:0] words;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             drain_en = 1'b0;
  logic [POP_W-1:0] result_pop = '0;
  logic [POP_W-1:0] status_pop = '0;
  logic [DW-1:0]    result_data = '0;
  logic [DW-1:0]    status_data = '0;
  logic             rd_en_result;
  logic             rd_en_status;
  logic [OW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] rec_count;
  logic             sync_err;
  logic [2:0]       dbg_state;

  pea_result_drain #(.POP_W(POP_W), .DW(DW), .OW(OW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .drain_en(drain_en),
    .result_pop(result_pop), .status_pop(status_pop),
    .result_data(result_data), .status_data(status_data),
    .rd_en_result(rd_en_result), .rd_en_status(rd_en_status),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .rec_count(rec_count), .sync_err(sync_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops = 0;

  logic [31:0] rq[$];
  logic [31:0] sq[$];
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] got_q[$];
  int got_cyc[$];

  logic        pend = 1'b0;
  logic [31:0] pend_rs = '0;
  logic [31:0] pend_st = '0;
  int          m_rec = 0;
  int          wcnt = 0;
  logic        exp_idle = 1'b0;
  logic        hold = 1'b0;
  logic [OW-1:0] hold_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO model, scoreboard and protocol monitor; runs mid-cycle after drivers settle.
  always @(negedge clk) begin
    #1;
    cyc++;
    if (pend) begin
      result_data = pend_rs;
      status_data = pend_st;
      pend = 1'b0;
    end
    if (rd_en_result || rd_en_status) begin
      check("strobe_pair", {31'd0, rd_en_result}, {31'd0, rd_en_status});
      check("no_underflow", {31'd0, (rq.size() > 0 && sq.size() > 0)}, 32'd1);
      if (rq.size() > 0 && sq.size() > 0) begin
        pend_rs = rq.pop_front();
        pend_st = sq.pop_front();
        pend = 1'b1;
        pops++;
        exp_q.push_back(pend_st[31:16]);
        exp_q.push_back(pend_st[15:0]);
        exp_q.push_back(pend_rs[31:16]);
        exp_q.push_back(pend_rs[15:0]);
      end
    end
    check("rec_count", {16'd0, rec_count}, m_rec);
    if (exp_idle) check("idle_after_rec", {31'd0, out_valid}, 32'd0);
    exp_idle = 1'b0;
    if (hold) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", {16'd0, out_data}, {16'd0, hold_data});
    end
    if (rst) begin
      m_rec = 0;
      wcnt = 0;
      exp_q.delete();
    end else if (out_valid && out_ready) begin
      check("word_expected", {31'd0, (exp_q.size() > 0)}, 32'd1);
      if (exp_q.size() > 0) check("word", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
      got_q.push_back(out_data);
      got_cyc.push_back(cyc);
      wcnt++;
      if (wcnt == 4) begin
        wcnt = 0;
        m_rec = (m_rec + 1) % (1 << CNT_W);
        exp_idle = 1'b1;
      end
    end
    hold = !rst && out_valid && !out_ready;
    hold_data = out_data;
    result_pop = POP_W'(rq.size());
    status_pop = POP_W'(sq.size());
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] st, input logic [31:0] rs);
    sq.push_back(st);
    rq.push_back(rs);
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("wait_words", got_q.size(), n);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  vec_t tbl[5];

  initial begin
    int base;
    int p0;
    int r0;
    logic [63:0] w;

    tbl[0] = '{st: 32'h0000_0001, rs: 32'h1234_ABCD, words: 64'h0000_0001_1234_ABCD};
    tbl[1] = '{st: 32'hDEAD_BEEF, rs: 32'h0000_0000, words: 64'hDEAD_BEEF_0000_0000};
    tbl[2] = '{st: 32'hFFFF_0000, rs: 32'h5A5A_A5A5, words: 64'hFFFF_0000_5A5A_A5A5};
    tbl[3] = '{st: 32'h8000_0001, rs: 32'hFFFF_FFFF, words: 64'h8000_0001_FFFF_FFFF};
    tbl[4] = '{st: 32'h0F0F_1234, rs: 32'hCAFE_F00D, words: 64'h0F0F_1234_CAFE_F00D};

    repeat (3) tick();
    check("rst_rd_en_result", {31'd0, rd_en_result}, 32'd0);
    check("rst_rd_en_status", {31'd0, rd_en_status}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sync_err", {31'd0, sync_err}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    tick();

    // Single record, consecutive words
    out_ready = 1'b1;
    drain_en = 1'b1;
    base = got_q.size();
    p0 = pops;
    push(tbl[0].st, tbl[0].rs);
    wait_words(base + 4, 50);
    for (int i = 1; i < 4; i++)
      check("consecutive", got_cyc[base + i] - got_cyc[base + i - 1], 1);
    repeat (3) tick();
    check("single_pops", pops - p0, 1);
    check("single_rec", {16'd0, rec_count}, 32'd1);
    check("single_busy", {31'd0, busy}, 32'd0);

    // Table-driven records, one at a time
    for (int t = 0; t < 5; t++) begin
      base = got_q.size();
      push(tbl[t].st, tbl[t].rs);
      wait_words(base + 4, 50);
      w = tbl[t].words;
      for (int i = 0; i < 4; i++)
        check("tbl_word", {16'd0, got_q[base + i]}, {16'd0, w[63 - 16*i -: 16]});
    end

    // Backpressure in S1
    base = got_q.size();
    p0 = pops;
    push(tbl[0].st, tbl[0].rs);
    wait_words(base + 1, 50);
    out_ready = 1'b0;
    repeat (5) begin
      tick();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data", {16'd0, out_data}, 32'h0001);
    end
    check("bp_pops", pops - p0, 1);
    out_ready = 1'b1;
    wait_words(base + 4, 50);
    check("bp_w2", {16'd0, got_q[base + 2]}, 32'h1234);
    check("bp_w3", {16'd0, got_q[base + 3]}, 32'hABCD);

    // Three queued records
    tick();
    drain_en = 1'b0;
    base = got_q.size();
    p0 = pops;
    r0 = rec_count;
    for (int t = 0; t < 3; t++) push(tbl[t].st, tbl[t].rs);
    tick();
    drain_en = 1'b1;
    wait_words(base + 12, 100);
    for (int t = 0; t < 3; t++) begin
      w = tbl[t].words;
      for (int i = 0; i < 4; i++)
        check("q3_word", {16'd0, got_q[base + 4*t + i]}, {16'd0, w[63 - 16*i -: 16]});
    end
    repeat (2) tick();
    check("q3_rec", {16'd0, rec_count}, (r0 + 3) % (1 << CNT_W));
    check("q3_pops", pops - p0, 3);
    check("q3_pop_empty", {27'd0, result_pop} | {27'd0, status_pop}, 32'd0);

    // Desync: result without status
    p0 = pops;
    base = got_q.size();
    rq.push_back(tbl[4].rs);
    repeat (3) tick();
    check("desync_flag", {31'd0, sync_err}, 32'd1);
    check("desync_no_pop", pops - p0, 0);
    sq.push_back(tbl[4].st);
    wait_words(base + 4, 50);
    w = tbl[4].words;
    for (int i = 0; i < 4; i++)
      check("desync_word", {16'd0, got_q[base + i]}, {16'd0, w[63 - 16*i -: 16]});
    check("desync_sticky", {31'd0, sync_err}, 32'd1);
    repeat (2) tick();
    pulse_reset();
    check("desync_cleared", {31'd0, sync_err}, 32'd0);
    check("desync_rst_rec", {16'd0, rec_count}, 32'd0);

    // drain_en gating
    drain_en = 1'b0;
    p0 = pops;
    base = got_q.size();
    push(tbl[1].st, tbl[1].rs);
    push(tbl[2].st, tbl[2].rs);
    repeat (10) begin
      tick();
      check("gate_no_valid", {31'd0, out_valid}, 32'd0);
    end
    check("gate_no_pop", pops - p0, 0);
    drain_en = 1'b1;
    wait_words(base + 2, 50);
    drain_en = 1'b0;
    wait_words(base + 4, 50);
    repeat (10) tick();
    check("gate_one_pop", pops - p0, 1);
    check("gate_left", rq.size(), 1);
    check("gate_idle", {31'd0, busy}, 32'd0);
    check("gate_rec", {16'd0, rec_count}, 32'd1);
    drain_en = 1'b1;
    wait_words(base + 8, 50);
    w = tbl[2].words;
    check("gate_rec2_w0", {16'd0, got_q[base + 4]}, {16'd0, w[63:48]});

    // Reset mid-record (during S1)
    repeat (3) tick();
    pulse_reset();
    base = got_q.size();
    push(tbl[3].st, tbl[3].rs);
    push(tbl[4].st, tbl[4].rs);
    wait_words(base + 1, 50);
    pulse_reset();
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_rec", {16'd0, rec_count}, 32'd0);
    check("mid_rst_state", {29'd0, dbg_state}, 32'd0);
    wait_words(base + 5, 50);
    w = tbl[4].words;
    for (int i = 0; i < 4; i++)
      check("mid_rst_word", {16'd0, got_q[base + 1 + i]}, {16'd0, w[63 - 16*i -: 16]});

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      drain_en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0 && rq.size() < 30) push($urandom, $urandom);
    end
    out_ready = 1'b1;
    drain_en = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      tick();
      if (rq.size() == 0 && exp_q.size() == 0 && !busy) break;
    end
    check("rand_fifo_empty", rq.size(), 0);
    check("rand_exp_empty", exp_q.size(), 0);
    check("rand_no_desync", {31'd0, sync_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
